sparse_compute_array: RTL and testbench
=======================================

# sparse_compute_array

Parametrised successor of the single-lane sparse compute unit. It accepts one sparse IFM chunk plus NUM_LANES sparse filter chunks per handshake. Each lane skips zeros by AND-ing sparsemaps and issues one matched product per cycle into a per-lane accumulator. Accumulators persist across chunks until a chunk flagged last completes, then all lanes present results over a valid/ready output port. It sits between the chunk fetch logic and the output buffer.

## Interface
- NUM_LANES, 4: parallel filter lanes sharing one IFM chunk
- CHUNK, 32: sparsemap bits per chunk (power of two, ≥4)
- DAT_W, 8: signed operand width
- OUT_W, 24: signed accumulator width (≥ 2·DAT_W + clog2(CHUNK))
- SAT, 1: 1 = saturate accumulate to signed OUT_W; 0 = two's-complement wrap
- clk_i  in  1  clock
- rst_i  in  1  reset; asynchronous, active-high
- in_valid_i  in  1  chunk offered
- in_ready_o  out  1  chunk accepted when in_valid_i & in_ready_o
- first_i  in  1  with accepted chunk: load accumulators from bias_i before accumulating
- last_i  in  1  with accepted chunk: present results after this chunk
- bias_i  in  NUM_LANES×OUT_W  per-lane initial value, sampled only when first_i
- ifm_map_i  in  CHUNK  IFM sparsemap
- ifm_dat_i  in  CHUNK×DAT_W  IFM nonzeros packed from index 0
- flt_map_i  in  NUM_LANES×CHUNK  filter sparsemaps
- flt_dat_i  in  NUM_LANES×CHUNK×DAT_W  filter nonzeros packed from index 0
- busy_o  out  1  state ≠ IDLE
- out_valid_o  out  1  results valid
- out_ready_i  in  1  consumer accepts results
- out_dat_o  out  NUM_LANES×OUT_W  per-lane accumulators
- sat_o  out  NUM_LANES  sticky per-lane saturation flag for the current result

## Operation
- FSM: IDLE, RUN, FLUSH, OUT.
- IDLE: in_ready_o = 1. Handshake registers maps, data, first_i and last_i. If first_i, acc ← bias_i and sat ← 0 in the same cycle. Next state is RUN.
- RUN, per lane: pend = ifm_map & flt_map & ~used. Pick the lowest set bit b and set used[b]. The IFM operand index is popcount(ifm_map[b-1:0]); the filter operand index is popcount(flt_map[b-1:0]). The signed product is registered. used clears on every accept.
- RUN exits to FLUSH when no lane has a pending bit after the current pick. A chunk with zero matches in every lane spends exactly 1 RUN cycle with no product issued.
- Accumulate: acc ← acc + prod one cycle after issue. Sign-extend the product to OUT_W.
- With SAT=1, overflow clamps to +2^(OUT_W-1)-1 or −2^(OUT_W-1) and sets sat_o[lane]. With SAT=0 the sum wraps and sat_o stays 0.
- FLUSH: one cycle that retires the final product. Next state is OUT if the latched last flag is set, otherwise IDLE.
- OUT: out_valid_o = 1 and out_dat_o = acc, both held stable until out_ready_i. On handshake, go to IDLE. Accumulators are not cleared on exit; the next first_i reloads them.
- A chunk accepted without first_i while the accumulators are fresh from reset accumulates onto 0.

## Timing
- Reset values: in_ready_o=1, busy_o=0, out_valid_o=0, out_dat_o=0, sat_o=0, all accumulators/used/product regs 0, state IDLE.
- Reset asserted mid-operation drops any chunk in flight and any unread result; no output handshake completes.
- Latency from accept cycle A, with M = max matches over lanes (M≥1, zero-match treated as 1):
  - RUN occupies A+1 … A+M.
  - FLUSH is at A+M+1.
  - out_valid_o rises at A+M+2 when last.
  - in_ready_o rises at A+M+2 when not last.
- in_ready_o is 0 in RUN, FLUSH and OUT. No back-to-back acceptance overlaps a chunk.
- out_valid_o does not depend combinationally on out_ready_i. in_ready_o does not depend combinationally on in_valid_i.

## Structure
- Package sca_pkg holds the state enum {IDLE, RUN, FLUSH, OUT} and a saturating-add function parametrised by OUT_W.
- Sub-module sca_lane (instantiated NUM_LANES times) contains:
  - the pend/used logic and the lowest-set-bit priority encoder;
  - both prefix popcounts and the two operand muxes;
  - the product register, accumulator and sat flag.
- The lane outputs "pending after pick". The top level ORs these across lanes and runs the FSM.

## Test plan
- NUM_LANES=4, CHUNK=32. IFM and all filter maps are all-ones; every data value is 1; first_i=last_i=1; bias 0. Expect RUN of 32 cycles, out_valid_o at A+34, out_dat_o=32 on every lane.
- ifm_map=0x0000_00F0 with data 3,−2,5,7. Lane0 flt_map=0x0000_0030 with data 4,6. Expect lane0 = 3·4 + (−2)·6 = 0. Other lanes have map 0 and return their bias 100. M=2, so out_valid_o at A+4.
- All maps zero, first_i=last_i=1, bias 5. Expect 1 RUN cycle, out_valid_o at A+3, out_dat_o=5 on every lane.
- Three chunks: first_i on chunk 1, last_i on chunk 3, each contributing +10 to lane2. Expect a single out_valid_o, after chunk 3 only, with lane2=30; in_ready_o returns between chunks.
- SAT=1, OUT_W=16, bias 32760, product 127·127. Expect out=32767 and sat_o=1. With SAT=0 the same stimulus gives the wrapped value and sat_o=0.
- Hold out_ready_i=0 for 5 cycles in OUT: out_dat_o stays stable and in_ready_o stays 0. Assert rst_i mid-RUN: all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/sca_pkg.sv
// Shared types for the sparse compute array: FSM states and the
// saturating accumulate helper used by every lane.
package sca_pkg;

   typedef enum logic [1:0] {IDLE, RUN, FLUSH, OUT} state_t;

   localparam int SUM_W = 64;

   typedef struct packed {
      logic                    ovf;
      logic signed [SUM_W-1:0] val;
   } sum_t;

   // Adds in a wide domain, then clamps to a signed w-bit range when satEn is set.
   function automatic sum_t satAdd(input logic signed [SUM_W-1:0] a,
                                   input logic signed [SUM_W-1:0] b,
                                   input int unsigned             w,
                                   input logic                    satEn);
      sum_t                    r;
      logic signed [SUM_W-1:0] s;
      logic signed [SUM_W-1:0] hi;
      logic signed [SUM_W-1:0] lo;
      s     = a + b;
      hi    = (64'sd1 <<< (w - 32'd1)) - 64'sd1;
      lo    = -hi - 64'sd1;
      r.ovf = 1'b0;
      r.val = s;
      if (satEn) begin
         if (s > hi) begin
            r.ovf = 1'b1;
            r.val = hi;
         end else if (s < lo) begin
            r.ovf = 1'b1;
            r.val = lo;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/sca_if.sv
// Chunk input and result output bundle of the sparse compute array.
// The array is the slave; the fetch logic / output buffer side is the master.
interface sca_if #(
   parameter int NUM_LANES = 4,
   parameter int CHUNK     = 32,
   parameter int DAT_W     = 8,
   parameter int OUT_W     = 24
) ();
   logic                               in_valid_i;
   logic                               in_ready_o;
   logic                               first_i;
   logic                               last_i;
   logic [NUM_LANES*OUT_W-1:0]         bias_i;
   logic [CHUNK-1:0]                   ifm_map_i;
   logic [CHUNK*DAT_W-1:0]             ifm_dat_i;
   logic [NUM_LANES*CHUNK-1:0]         flt_map_i;
   logic [NUM_LANES*CHUNK*DAT_W-1:0]   flt_dat_i;
   logic                               busy_o;
   logic                               out_valid_o;
   logic                               out_ready_i;
   logic [NUM_LANES*OUT_W-1:0]         out_dat_o;
   logic [NUM_LANES-1:0]               sat_o;

   modport slave (
      input  in_valid_i, first_i, last_i, bias_i, ifm_map_i, ifm_dat_i,
             flt_map_i, flt_dat_i, out_ready_i,
      output in_ready_o, busy_o, out_valid_o, out_dat_o, sat_o
   );

   modport master (
      output in_valid_i, first_i, last_i, bias_i, ifm_map_i, ifm_dat_i,
             flt_map_i, flt_dat_i, out_ready_i,
      input  in_ready_o, busy_o, out_valid_o, out_dat_o, sat_o
   );
endinterface

// File: rtl/sca_lane.sv
// One filter lane: walks matching nonzeros lowest-index first, issues one
// registered product per cycle and accumulates it on the following cycle.
module sca_lane
   import sca_pkg::*;
#(
   parameter int CHUNK = 32,
   parameter int DAT_W = 8,
   parameter int OUT_W = 24,
   parameter int SAT   = 1
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     run_i,
   input  logic                     accept_i,
   input  logic                     first_i,
   input  logic [OUT_W-1:0]         bias_i,
   input  logic [CHUNK-1:0]         ifmMap_i,
   input  logic [CHUNK*DAT_W-1:0]   ifmDat_i,
   input  logic [CHUNK-1:0]         fltMap_i,
   input  logic [CHUNK*DAT_W-1:0]   fltDat_i,
   output logic                     pendAfter_o,
   output logic [OUT_W-1:0]         acc_o,
   output logic                     sat_o
);
   localparam int IDX_W = $clog2(CHUNK);

   logic [CHUNK-1:0]          used_q;
   logic [CHUNK-1:0]          pend;
   logic [CHUNK-1:0]          pick;
   logic [CHUNK-1:0]          below;
   logic [IDX_W-1:0]          ifmIdx;
   logic [IDX_W-1:0]          fltIdx;
   logic signed [DAT_W-1:0]   ifmOp;
   logic signed [DAT_W-1:0]   fltOp;
   logic signed [2*DAT_W-1:0] prod_q;
   logic signed [2*DAT_W-1:0] prod_d;
   logic                      prodValid_q;
   logic [OUT_W-1:0]          acc_q;
   logic [OUT_W-1:0]          acc_d;
   logic                      sat_q;
   logic                      sat_d;
   sum_t                      sum;

   // Operand positions are the counts of set map bits strictly below the picked index.
   always_comb begin
      pend        = ifmMap_i & fltMap_i & ~used_q;
      pick        = pend & (~pend + CHUNK'(1));
      below       = pick - CHUNK'(1);
      pendAfter_o = |(pend & ~pick);
      ifmIdx      = '0;
      fltIdx      = '0;
      for (int i = 0; i < CHUNK; i++) begin
         ifmIdx = ifmIdx + IDX_W'(ifmMap_i[i] & below[i]);
         fltIdx = fltIdx + IDX_W'(fltMap_i[i] & below[i]);
      end
      ifmOp  = ifmDat_i[ifmIdx*DAT_W +: DAT_W];
      fltOp  = fltDat_i[fltIdx*DAT_W +: DAT_W];
      prod_d = (2*DAT_W)'(ifmOp) * (2*DAT_W)'(fltOp);
      sum    = satAdd({{(SUM_W-OUT_W){acc_q[OUT_W-1]}}, acc_q},
                      {{(SUM_W-2*DAT_W){prod_q[2*DAT_W-1]}}, prod_q},
                      OUT_W, SAT != 0);
      acc_d  = OUT_W'(sum.val);
      sat_d  = sat_q | sum.ovf;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         used_q      <= '0;
         prod_q      <= '0;
         prodValid_q <= 1'b0;
         acc_q       <= '0;
         sat_q       <= 1'b0;
      end else begin
         prodValid_q <= 1'b0;
         if (accept_i) begin
            used_q <= '0;
         end else if (run_i && (pick != '0)) begin
            used_q      <= used_q | pick;
            prod_q      <= prod_d;
            prodValid_q <= 1'b1;
         end
         if (accept_i && first_i) begin
            acc_q <= bias_i;
            sat_q <= 1'b0;
         end else if (prodValid_q) begin
            acc_q <= acc_d;
            sat_q <= sat_d;
         end
      end
   end

   assign acc_o = acc_q;
   assign sat_o = sat_q;

endmodule

// File: rtl/sparse_compute_array.sv
// Multi-lane sparse dot-product engine: one IFM chunk shared by NUM_LANES
// filter lanes, results presented once a chunk flagged last has retired.
module sparse_compute_array
   import sca_pkg::*;
#(
   parameter int NUM_LANES = 4,
   parameter int CHUNK     = 32,
   parameter int DAT_W     = 8,
   parameter int OUT_W     = 24,
   parameter int SAT       = 1
) (
   input logic  clk_i,
   input logic  rst_i,
   sca_if.slave bus
);
   state_t                             state_q;
   logic                               inReady_q;
   logic                               busy_q;
   logic                               outValid_q;
   logic                               last_q;
   logic [CHUNK-1:0]                   ifmMap_q;
   logic [CHUNK*DAT_W-1:0]             ifmDat_q;
   logic [NUM_LANES*CHUNK-1:0]         fltMap_q;
   logic [NUM_LANES*CHUNK*DAT_W-1:0]   fltDat_q;
   logic [NUM_LANES-1:0]               lanePend;
   logic [NUM_LANES*OUT_W-1:0]         laneAcc;
   logic [NUM_LANES-1:0]               laneSat;
   logic                               accept;
   logic                               anyPend;
   logic                               run;

   assign accept  = bus.in_valid_i & inReady_q;
   assign anyPend = |lanePend;
   assign run     = (state_q == RUN);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ifmMap_q <= '0;
         ifmDat_q <= '0;
         fltMap_q <= '0;
         fltDat_q <= '0;
      end else if (accept) begin
         ifmMap_q <= bus.ifm_map_i;
         ifmDat_q <= bus.ifm_dat_i;
         fltMap_q <= bus.flt_map_i;
         fltDat_q <= bus.flt_dat_i;
      end
   end

   // RUN ends on the cycle where the last outstanding pick across all lanes issues.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         inReady_q  <= 1'b1;
         busy_q     <= 1'b0;
         outValid_q <= 1'b0;
         last_q     <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  state_q   <= RUN;
                  inReady_q <= 1'b0;
                  busy_q    <= 1'b1;
                  last_q    <= bus.last_i;
               end
            end
            RUN: begin
               if (!anyPend) state_q <= FLUSH;
            end
            FLUSH: begin
               if (last_q) begin
                  state_q    <= OUT;
                  outValid_q <= 1'b1;
               end else begin
                  state_q   <= IDLE;
                  inReady_q <= 1'b1;
                  busy_q    <= 1'b0;
               end
            end
            OUT: begin
               if (bus.out_ready_i) begin
                  state_q    <= IDLE;
                  outValid_q <= 1'b0;
                  inReady_q  <= 1'b1;
                  busy_q     <= 1'b0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   for (genvar l = 0; l < NUM_LANES; l++) begin : gLane
      sca_lane #(
         .CHUNK (CHUNK),
         .DAT_W (DAT_W),
         .OUT_W (OUT_W),
         .SAT   (SAT)
      ) uLane (
         .clk_i       (clk_i),
         .rst_i       (rst_i),
         .run_i       (run),
         .accept_i    (accept),
         .first_i     (bus.first_i),
         .bias_i      (bus.bias_i[l*OUT_W +: OUT_W]),
         .ifmMap_i    (ifmMap_q),
         .ifmDat_i    (ifmDat_q),
         .fltMap_i    (fltMap_q[l*CHUNK +: CHUNK]),
         .fltDat_i    (fltDat_q[l*CHUNK*DAT_W +: CHUNK*DAT_W]),
         .pendAfter_o (lanePend[l]),
         .acc_o       (laneAcc[l*OUT_W +: OUT_W]),
         .sat_o       (laneSat[l])
      );
   end

   assign bus.in_ready_o  = inReady_q;
   assign bus.busy_o      = busy_q;
   assign bus.out_valid_o = outValid_q;
   assign bus.out_dat_o   = laneAcc;
   assign bus.sat_o       = laneSat;

endmodule

// File: tb/tb_sparse_compute_array.sv
// Scoreboard bench: chunks are built from dense vectors, a dense dot-product
// model predicts each result, and a monitor process checks results as they appear.
module tb_sparse_compute_array;
   localparam int NL  = 4;
   localparam int CH  = 32;
   localparam int DW  = 8;
   localparam int OW  = 24;
   localparam int SAT = 1;
   localparam longint ACC_MAX = (longint'(1) <<< (OW - 1)) - 1;
   localparam longint ACC_MIN = -ACC_MAX - 1;

   typedef struct {
      logic [NL*OW-1:0] dat;
      logic [NL-1:0]    sat;
      longint           cyc;
   } exp_t;

   logic   clk = 1'b0;
   logic   rst = 1'b1;
   longint cyc = 0;
   int     testsRun = 0;
   int     testsFailed = 0;
   int     stallCnt = 0;
   int     dIfm [CH];
   int     dFlt [NL][CH];
   longint biasV [NL];
   longint mAcc [NL];
   bit     mSat [NL];
   exp_t   expQ [$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   sca_if #(.NUM_LANES(NL), .CHUNK(CH), .DAT_W(DW), .OUT_W(OW)) bus ();

   sparse_compute_array #(
      .NUM_LANES (NL),
      .CHUNK     (CH),
      .DAT_W     (DW),
      .OUT_W     (OW),
      .SAT       (SAT)
   ) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] req);
      testsRun++;
      if (act !== req) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   function automatic longint wrapAcc(input longint v);
      logic signed [OW-1:0] t;
      t = v[OW-1:0];
      return longint'(t);
   endfunction

   function automatic int nzVal();
      int v;
      v = int'($urandom_range(0, 254)) - 127;
      if (v == 0) v = -128;
      return v;
   endfunction

   task automatic clearDense();
      for (int b = 0; b < CH; b++) begin
         dIfm[b] = 0;
         for (int l = 0; l < NL; l++) dFlt[l][b] = 0;
      end
      for (int l = 0; l < NL; l++) biasV[l] = 0;
   endtask

   task automatic makeRandom();
      int dens;
      dens = int'($urandom_range(5, 90));
      for (int b = 0; b < CH; b++) begin
         dIfm[b] = (int'($urandom_range(0, 99)) < dens) ? nzVal() : 0;
         for (int l = 0; l < NL; l++)
            dFlt[l][b] = (int'($urandom_range(0, 99)) < dens) ? nzVal() : 0;
      end
      for (int l = 0; l < NL; l++) begin
         case ($urandom_range(0, 3))
            0:       biasV[l] = ACC_MAX - longint'($urandom_range(0, 30000));
            1:       biasV[l] = ACC_MIN + longint'($urandom_range(0, 30000));
            default: biasV[l] = longint'($urandom_range(0, 2000000)) - 1000000;
         endcase
      end
   endtask

   // Offers the dense chunk packed as sparsemap + nonzeros, updates the model after acceptance.
   task automatic applyStimulus(input bit first, input bit last, input bit expectResult);
      int     k;
      int     m;
      int     cnt;
      bit     got;
      longint acceptCyc;
      longint p;
      exp_t   e;
      got = 1'b0;
      for (int i = 0; i < 500 && !got; i++) begin
         @(negedge clk);
         if (bus.in_ready_o) got = 1'b1;
      end
      if (!got) begin
         testsRun++;
         testsFailed++;
         $display("[TB] FAIL inReadyTimeout: got 0, expected 1");
         return;
      end
      bus.first_i = first;
      bus.last_i  = last;
      for (int l = 0; l < NL; l++) bus.bias_i[l*OW +: OW] = OW'(biasV[l]);
      bus.ifm_map_i = '0;
      for (int i = 0; i < CH; i++) bus.ifm_dat_i[i*DW +: DW] = DW'($urandom);
      k = 0;
      for (int b = 0; b < CH; b++) begin
         if (dIfm[b] != 0) begin
            bus.ifm_map_i[b] = 1'b1;
            bus.ifm_dat_i[k*DW +: DW] = DW'(dIfm[b]);
            k++;
         end
      end
      bus.flt_map_i = '0;
      for (int l = 0; l < NL; l++) begin
         for (int i = 0; i < CH; i++) bus.flt_dat_i[(l*CH+i)*DW +: DW] = DW'($urandom);
         k = 0;
         for (int b = 0; b < CH; b++) begin
            if (dFlt[l][b] != 0) begin
               bus.flt_map_i[l*CH+b] = 1'b1;
               bus.flt_dat_i[(l*CH+k)*DW +: DW] = DW'(dFlt[l][b]);
               k++;
            end
         end
      end
      bus.in_valid_i = 1'b1;
      acceptCyc = cyc;
      @(posedge clk);
      #1;
      bus.in_valid_i = 1'b0;
      bus.first_i    = 1'b0;
      bus.last_i     = 1'b0;

      m = 1;
      for (int l = 0; l < NL; l++) begin
         if (first) begin
            mAcc[l] = biasV[l];
            mSat[l] = 1'b0;
         end
         cnt = 0;
         for (int b = 0; b < CH; b++) begin
            if (dIfm[b] != 0 && dFlt[l][b] != 0) begin
               cnt++;
               p = longint'(dIfm[b]) * longint'(dFlt[l][b]);
               mAcc[l] = mAcc[l] + p;
               if (SAT != 0) begin
                  if (mAcc[l] > ACC_MAX) begin mAcc[l] = ACC_MAX; mSat[l] = 1'b1; end
                  if (mAcc[l] < ACC_MIN) begin mAcc[l] = ACC_MIN; mSat[l] = 1'b1; end
               end else begin
                  mAcc[l] = wrapAcc(mAcc[l]);
               end
            end
         end
         if (cnt > m) m = cnt;
      end
      if (last && expectResult) begin
         for (int l = 0; l < NL; l++) begin
            e.dat[l*OW +: OW] = OW'(mAcc[l]);
            e.sat[l]          = mSat[l];
         end
         e.cyc = acceptCyc + longint'(m) + 2;
         expQ.push_back(e);
      end

      @(negedge clk);
      checkOutput("busyInRun", 128'(bus.busy_o), 128'(1));
      checkOutput("inReadyInRun", 128'(bus.in_ready_o), 128'(0));
      if (!last) begin
         for (int i = 0; i < 300 && !bus.in_ready_o; i++) @(negedge clk);
         checkOutput("inReadyRiseCycle", 128'(cyc), 128'(acceptCyc + longint'(m) + 2));
      end
   endtask

   // Result monitor: pops the scoreboard on each new result, checks it stays held while stalled.
   initial begin
      exp_t e;
      bit   inOut;
      inOut = 1'b0;
      e.dat = '0;
      e.sat = '0;
      e.cyc = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            inOut = 1'b0;
            bus.out_ready_i = 1'b0;
            continue;
         end
         if (bus.out_valid_o) begin
            if (!inOut) begin
               inOut = 1'b1;
               if (expQ.size() == 0) begin
                  testsRun++;
                  testsFailed++;
                  $display("[TB] FAIL unexpectedResult: got out_valid_o=1, expected no result");
               end else begin
                  e = expQ.pop_front();
                  checkOutput("outDat", 128'(bus.out_dat_o), 128'(e.dat));
                  checkOutput("satFlags", 128'(bus.sat_o), 128'(e.sat));
                  checkOutput("validCycle", 128'(cyc), 128'(e.cyc));
               end
            end else begin
               checkOutput("outHold", 128'(bus.out_dat_o), 128'(e.dat));
               checkOutput("inReadyInOut", 128'(bus.in_ready_o), 128'(0));
            end
            if (stallCnt > 0) begin
               stallCnt--;
               bus.out_ready_i = 1'b0;
            end else begin
               bus.out_ready_i = 1'($urandom_range(0, 1));
            end
            if (bus.out_ready_i) inOut = 1'b0;
         end else begin
            bus.out_ready_i = (stallCnt > 0) ? 1'b0 : 1'($urandom_range(0, 1));
         end
      end
   end

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "InReady"}, 128'(bus.in_ready_o), 128'(1));
      checkOutput({tag, "Busy"}, 128'(bus.busy_o), 128'(0));
      checkOutput({tag, "OutValid"}, 128'(bus.out_valid_o), 128'(0));
      checkOutput({tag, "OutDat"}, 128'(bus.out_dat_o), 128'(0));
      checkOutput({tag, "Sat"}, 128'(bus.sat_o), 128'(0));
   endtask

   initial begin
      bus.in_valid_i = 1'b0;
      bus.first_i    = 1'b0;
      bus.last_i     = 1'b0;
      bus.bias_i     = '0;
      bus.ifm_map_i  = '0;
      bus.ifm_dat_i  = '0;
      bus.flt_map_i  = '0;
      bus.flt_dat_i  = '0;
      bus.out_ready_i = 1'b0;
      for (int l = 0; l < NL; l++) begin mAcc[l] = 0; mSat[l] = 1'b0; end
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checkResetOutputs("reset");
      rst = 1'b0;

      // Dense all-ones chunk: 32 matches per lane.
      clearDense();
      for (int b = 0; b < CH; b++) begin
         dIfm[b] = 1;
         for (int l = 0; l < NL; l++) dFlt[l][b] = 1;
      end
      applyStimulus(1'b1, 1'b1, 1'b1);

      clearDense();
      dIfm[4] = 3; dIfm[5] = -2; dIfm[6] = 5; dIfm[7] = 7;
      dFlt[0][4] = 4; dFlt[0][5] = 6;
      biasV[1] = 100; biasV[2] = 100; biasV[3] = 100;
      applyStimulus(1'b1, 1'b1, 1'b1);

      clearDense();
      for (int l = 0; l < NL; l++) biasV[l] = 5;
      applyStimulus(1'b1, 1'b1, 1'b1);

      clearDense();
      dIfm[0] = 2; dFlt[2][0] = 5;
      applyStimulus(1'b1, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b1, 1'b1);

      clearDense();
      biasV[0] = ACC_MAX - 7;
      biasV[1] = ACC_MIN + 7;
      dIfm[3] = 127; dFlt[0][3] = 127; dFlt[1][3] = -128;
      applyStimulus(1'b1, 1'b1, 1'b1);

      stallCnt = 5;
      makeRandom();
      applyStimulus(1'b1, 1'b1, 1'b1);

      for (int g = 0; g < 25; g++) begin
         int len;
         len = int'($urandom_range(1, 3));
         for (int c = 0; c < len; c++) begin
            makeRandom();
            applyStimulus(c == 0, c == len - 1, 1'b1);
         end
      end

      // Reset while the chunk is still in RUN; the result must never appear.
      clearDense();
      for (int b = 0; b < CH; b++) begin
         dIfm[b] = 1;
         for (int l = 0; l < NL; l++) dFlt[l][b] = 1;
      end
      applyStimulus(1'b1, 1'b1, 1'b0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1;
      checkResetOutputs("midRunReset");
      for (int l = 0; l < NL; l++) begin mAcc[l] = 0; mSat[l] = 1'b0; end
      @(negedge clk);
      rst = 1'b0;

      makeRandom();
      applyStimulus(1'b0, 1'b1, 1'b1);

      for (int i = 0; i < 500 && (expQ.size() != 0 || bus.out_valid_o); i++) @(negedge clk);
      checkOutput("drainPending", 128'(expQ.size()), 128'(0));
      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
